// File: rtl/rescale_pkg.sv
// Shared constants and helpers for the rescale stream datapath.
package rescale_pkg;

  // Rounding mode encodings carried on up_round.
  localparam logic RND_TRUNC   = 1'b0;
  localparam logic RND_HALF_UP = 1'b1;

  // Largest value representable in a signed field of the given width.
  function automatic longint img_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a signed field of the given width.
  function automatic longint img_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/rescale_stream_if.sv
// Upstream and downstream valid/ready stream bundle for the rescale stage.
interface rescale_stream_if #(
  parameter int LANES       = 4,
  parameter int NUM_WIDTH   = 33,
  parameter int IMG_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 8
);
  logic [LANES*NUM_WIDTH-1:0] up_data;
  logic [SHIFT_WIDTH-1:0]     up_shift;
  logic                       up_round;
  logic                       up_relu;
  logic                       up_valid;
  logic                       up_ready;
  logic [LANES*IMG_WIDTH-1:0] dn_data;
  logic [LANES-1:0]           dn_sat;
  logic                       dn_valid;
  logic                       dn_ready;

  // Producer of beats / consumer of results.
  modport master (
    output up_data, up_shift, up_round, up_relu, up_valid, dn_ready,
    input  up_ready, dn_data, dn_sat, dn_valid
  );

  // The rescale stage itself.
  modport slave (
    input  up_data, up_shift, up_round, up_relu, up_valid, dn_ready,
    output up_ready, dn_data, dn_sat, dn_valid
  );
endinterface

// File: rtl/rescale_lane.sv
// One lane of the rescale datapath: S1 shift/round, S2 saturate/ReLU.
module rescale_lane
  import rescale_pkg::*;
#(
  parameter int NUM_WIDTH   = 33,
  parameter int IMG_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_s1,
  input  logic                        en_s2,
  input  logic signed [NUM_WIDTH-1:0] data,
  input  logic [SHIFT_WIDTH-1:0]      shift,
  input  logic                        rnd,
  input  logic                        relu,
  output logic [IMG_WIDTH-1:0]        out,
  output logic                        sat
);
  // One guard bit so the rounding bias never wraps the sum.
  localparam int WW = NUM_WIDTH + 1;
  localparam int unsigned SHIFT_MAX = NUM_WIDTH - 1;
  localparam logic signed [WW-1:0] R_MAX = WW'(img_max(IMG_WIDTH));
  localparam logic signed [WW-1:0] R_MIN = WW'(img_min(IMG_WIDTH));
  localparam logic [IMG_WIDTH-1:0] OUT_MAX = IMG_WIDTH'(img_max(IMG_WIDTH));
  localparam logic [IMG_WIDTH-1:0] OUT_MIN = IMG_WIDTH'(img_min(IMG_WIDTH));

  logic [SHIFT_WIDTH-1:0] s_eff;
  logic signed [WW-1:0]   x;
  logic signed [WW-1:0]   bias;
  logic signed [WW-1:0]   sum;
  logic signed [WW-1:0]   r_next;
  logic signed [WW-1:0]   r_reg;
  logic                   relu_reg;
  logic [IMG_WIDTH-1:0]   out_next;
  logic                   sat_next;
  logic [IMG_WIDTH-1:0]   out_reg;
  logic                   sat_reg;

  // S1 combinational: clamp the shift, add the half-LSB bias, arithmetic shift.
  always_comb begin
    s_eff = shift;
    if (32'(shift) > SHIFT_MAX) s_eff = SHIFT_WIDTH'(SHIFT_MAX);
    x    = {data[NUM_WIDTH-1], data};
    bias = '0;
    if (rnd == RND_HALF_UP && s_eff != '0) bias = WW'(1) <<< (s_eff - 1'b1);
    sum    = x + bias;
    r_next = sum >>> s_eff;
  end

  // S1 register: shifted value and the ReLU mode travelling with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg    <= '0;
      relu_reg <= 1'b0;
    end else if (en_s1) begin
      r_reg    <= r_next;
      relu_reg <= relu;
    end
  end

  // S2 combinational: saturate to the image range, then optional ReLU.
  always_comb begin
    out_next = r_reg[IMG_WIDTH-1:0];
    sat_next = 1'b0;
    if (r_reg > R_MAX) begin
      out_next = OUT_MAX;
      sat_next = 1'b1;
    end else if (r_reg < R_MIN) begin
      out_next = OUT_MIN;
      sat_next = 1'b1;
    end
    if (relu_reg && out_next[IMG_WIDTH-1]) out_next = '0;
  end

  // S2 register: lane result and its saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= '0;
      sat_reg <= 1'b0;
    end else if (en_s2) begin
      out_reg <= out_next;
      sat_reg <= sat_next;
    end
  end

  assign out = out_reg;
  assign sat = sat_reg;
endmodule

// File: rtl/rescale_stream.sv
// Multi-lane rescale stage: valid pipeline, handshake, output stage, saturation counter.
module rescale_stream
  import rescale_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int NUM_WIDTH   = 33,
  parameter int IMG_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rescale_stream_if.slave      bus,
  input  logic                 sat_clear,
  output logic [CNT_WIDTH-1:0] sat_count
);
  logic                       en;
  logic                       v1_reg;
  logic                       v2_reg;
  logic                       dn_valid_reg;
  logic [LANES*IMG_WIDTH-1:0] lane_out;
  logic [LANES-1:0]           lane_sat;
  logic [LANES*IMG_WIDTH-1:0] dn_data_reg;
  logic [LANES-1:0]           dn_sat_reg;
  logic [CNT_WIDTH-1:0]       sat_count_reg;

  // The whole pipeline moves as one unit whenever the output slot can drain.
  assign en           = ~dn_valid_reg | bus.dn_ready;
  assign bus.up_ready = rst_n & en;

  // Per-lane datapath; data registers only load for valid beats.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    rescale_lane #(
      .NUM_WIDTH  (NUM_WIDTH),
      .IMG_WIDTH  (IMG_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .en_s1(en & bus.up_valid),
      .en_s2(en & v1_reg),
      .data (bus.up_data[gi*NUM_WIDTH +: NUM_WIDTH]),
      .shift(bus.up_shift),
      .rnd  (bus.up_round),
      .relu (bus.up_relu),
      .out  (lane_out[gi*IMG_WIDTH +: IMG_WIDTH]),
      .sat  (lane_sat[gi])
    );
  end

  // Stage valid bits advance together under the common enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg       <= 1'b0;
      v2_reg       <= 1'b0;
      dn_valid_reg <= 1'b0;
    end else if (en) begin
      v1_reg       <= bus.up_valid;
      v2_reg       <= v1_reg;
      dn_valid_reg <= v2_reg;
    end
  end

  // S3 output register: loads only when a valid beat enters, holds during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_data_reg <= '0;
      dn_sat_reg  <= '0;
    end else if (en && v2_reg) begin
      dn_data_reg <= lane_out;
      dn_sat_reg  <= lane_sat;
    end
  end

  // Count delivered beats with any saturated lane; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count_reg <= '0;
    end else if (sat_clear) begin
      sat_count_reg <= '0;
    end else if (dn_valid_reg && bus.dn_ready && (|dn_sat_reg) && sat_count_reg != '1) begin
      sat_count_reg <= sat_count_reg + 1'b1;
    end
  end

  assign bus.dn_data  = dn_data_reg;
  assign bus.dn_sat   = dn_sat_reg;
  assign bus.dn_valid = dn_valid_reg;
  assign sat_count    = sat_count_reg;
endmodule

// File: tb/tb_rescale_stream.sv
// Self-checking bench for rescale_stream: table vectors plus handshake corner sequences.
module tb_rescale_stream;
  import rescale_pkg::*;

  localparam int LANES = 4;
  localparam int NW    = 33;
  localparam int IW    = 16;
  localparam int SW    = 8;
  localparam int CW    = 16;
  localparam int NVEC  = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sat_clear = 1'b0;
  logic [CW-1:0] sat_count;

  rescale_stream_if #(.LANES(LANES), .NUM_WIDTH(NW), .IMG_WIDTH(IW), .SHIFT_WIDTH(SW)) bus ();

  rescale_stream #(
    .LANES(LANES), .NUM_WIDTH(NW), .IMG_WIDTH(IW), .SHIFT_WIDTH(SW), .CNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sat_clear(sat_clear),
    .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES*NW-1:0] data;
    logic [SW-1:0]       shift;
    logic                rnd;
    logic                relu;
    logic [LANES*IW-1:0] exp;
    logic [LANES-1:0]    esat;
  } vec_t;

  typedef struct packed {
    logic [LANES*IW-1:0] data;
    logic [LANES-1:0]    sat;
  } exp_t;

  vec_t          vecs [NVEC];
  exp_t          sb [$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            beats = 0;
  int            acc_cnt = 0;
  logic [CW-1:0] exp_cnt = '0;
  bit            done_flag = 0;
  logic [63:0]   stall_held;
  bit            stall_have;

  function automatic logic [LANES*NW-1:0] p4(input longint a, input longint b, input longint c, input longint d);
    return {NW'(d), NW'(c), NW'(b), NW'(a)};
  endfunction

  function automatic logic [LANES*IW-1:0] q4(input int a, input int b, input int c, input int d);
    return {IW'(d), IW'(c), IW'(b), IW'(a)};
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic send(input vec_t v);
    int   n;
    exp_t e;
    n = 0;
    bus.up_data  = v.data;
    bus.up_shift = v.shift;
    bus.up_round = v.rnd;
    bus.up_relu  = v.relu;
    bus.up_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.up_ready) begin
        e.data = v.exp;
        e.sat  = v.esat;
        sb.push_back(e);
        acc_cnt++;
        break;
      end
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: up_ready never rose within 200 cycles");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.up_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_outstanding", sb.size(), 0);
  endtask

  // Scoreboard: pop expected beat on every completed downstream handshake, track sat_count.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      exp_cnt = '0;
    end else begin
      check("sat_count", sat_count, exp_cnt);
      if (bus.dn_valid && bus.dn_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: data=%h sat=%b with nothing outstanding", bus.dn_data, bus.dn_sat);
        end else begin
          mon_e = sb.pop_front();
          check("dn_data", bus.dn_data, mon_e.data);
          check("dn_sat", bus.dn_sat, mon_e.sat);
          $display("beat %0d data=%h sat=%b", beats, bus.dn_data, bus.dn_sat);
          beats++;
          if (!sat_clear && mon_e.sat != '0 && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        end
      end
      if (sat_clear) exp_cnt = '0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.up_data  = '0;
    bus.up_shift = '0;
    bus.up_round = RND_TRUNC;
    bus.up_relu  = 1'b0;
    bus.up_valid = 1'b0;
    bus.dn_ready = 1'b1;

    vecs[0]  = '{p4(64'h12345, 24, -24, 7), 8'd4, RND_TRUNC, 1'b0, q4('h1234, 1, -2, 0), 4'b0000};
    vecs[1]  = '{p4(64'h12345, 24, -24, 7), 8'd4, RND_HALF_UP, 1'b0, q4('h1234, 2, -1, 0), 4'b0000};
    vecs[2]  = '{p4(1 << 20, -(1 << 20), 0, 0), 8'd4, RND_TRUNC, 1'b0, q4('h7FFF, 'h8000, 0, 0), 4'b0011};
    vecs[3]  = '{p4(65535, 65534, -65536, -65537), 8'd1, RND_HALF_UP, 1'b0, q4('h7FFF, 'h7FFF, 'h8000, 'h8000), 4'b0001};
    vecs[4]  = '{p4(-5, -(1 << 20), 5, 0), 8'd0, RND_TRUNC, 1'b1, q4(0, 0, 5, 0), 4'b0010};
    vecs[5]  = '{p4(0, -(1 << 20), 100, -100), 8'd4, RND_TRUNC, 1'b1, q4(0, 0, 6, 0), 4'b0010};
    vecs[6]  = '{p4(0, 12345, -12345, 64'd4294967295), 8'd200, RND_TRUNC, 1'b0, q4(0, 0, -1, 0), 4'b0000};
    vecs[7]  = '{p4(64'd4294967295, -64'd4294967296, 64'd2147483648, 64'd2147483647), 8'd200, RND_HALF_UP, 1'b0,
                 q4(1, -1, 1, 0), 4'b0000};
    vecs[8]  = '{p4(-1, 1, 0, 0), 8'd255, RND_TRUNC, 1'b0, q4(-1, 0, 0, 0), 4'b0000};
    vecs[9]  = '{p4(32767, -32768, 32768, -32769), 8'd0, RND_TRUNC, 1'b0, q4('h7FFF, 'h8000, 'h7FFF, 'h8000), 4'b1100};
    vecs[10] = '{p4(64'h18000, -64'h18000, 64'h17FFF, -64'h8000), 8'd16, RND_HALF_UP, 1'b0, q4(2, -1, 1, 0), 4'b0000};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_dn_valid", bus.dn_valid, 0);
    check("rst_dn_data", bus.dn_data, 0);
    check("rst_dn_sat", bus.dn_sat, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_up_ready", bus.up_ready, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_up_ready", bus.up_ready, 1);

    // Table pass, back-to-back beats, downstream always ready.
    for (int i = 0; i < NVEC; i++) send(vecs[i]);
    idle();
    drain();

    // Table pass again under random downstream backpressure.
    done_flag = 0;
    fork
      begin
        for (int i = 0; i < NVEC; i++) send(vecs[i]);
        idle();
        done_flag = 1;
      end
      begin
        while (!done_flag) begin
          @(posedge clk);
          #1;
          bus.dn_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.dn_ready = 1'b1;
    drain();

    // Stall: dn_ready low for 6 clk while 5 beats are offered.
    acc_cnt = 0;
    stall_have = 0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(vecs[i]);
        idle();
      end
      begin
        bus.dn_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (bus.dn_valid) begin
            if (!stall_have) begin
              stall_held = bus.dn_data;
              stall_have = 1;
            end else begin
              check("stall_data_hold", bus.dn_data, stall_held);
            end
          end
        end
        check("stall_accepts", acc_cnt, 3);
        check("stall_up_ready", bus.up_ready, 0);
        check("stall_dn_valid", bus.dn_valid, 1);
        @(posedge clk);
        #1;
        bus.dn_ready = 1'b1;
      end
    join
    drain();

    // sat_clear coincident with a saturating output beat.
    send(vecs[2]);
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("clr_dn_valid", bus.dn_valid, 1);
    check("clr_dn_sat", bus.dn_sat, 4'b0011);
    sat_clear = 1'b1;
    @(posedge clk);
    #1;
    sat_clear = 1'b0;
    check("clr_sat_count", sat_count, 0);
    check("clr_dn_valid_after", bus.dn_valid, 0);

    // Asynchronous reset with three beats in flight.
    for (int i = 0; i < 3; i++) send(vecs[i]);
    idle();
    check("pre_rst_dn_valid", bus.dn_valid, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_dn_valid", bus.dn_valid, 0);
    check("async_rst_up_ready", bus.up_ready, 0);
    check("async_rst_dn_data", bus.dn_data, 0);
    check("async_rst_dn_sat", bus.dn_sat, 0);
    check("async_rst_sat_count", sat_count, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("no_stale_beat", bus.dn_valid, 0);
    end
    @(posedge clk);
    #1;
    send(vecs[1]);
    idle();
    @(negedge clk);
    check("lat_cycle1", bus.dn_valid, 0);
    @(negedge clk);
    check("lat_cycle2", bus.dn_valid, 0);
    @(negedge clk);
    check("lat_cycle3", bus.dn_valid, 1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rescale_stream.md
Name: rescale_stream

Overview:
Multi-lane, flow-controlled successor to the single-lane rescale stage. Takes LANES signed MAC/ADD accumulator values per beat and applies a per-beat arithmetic right shift. Optionally rounds, saturates to the signed image width, and optionally applies ReLU. Sits between the MAC/ADD array and the image write-back path, with a valid/ready handshake on both sides and a saturation-event counter for software.

Parameters:
LANES, 4, number of parallel channels per beat
NUM_WIDTH, 33, signed accumulator width per lane
IMG_WIDTH, 16, signed output image width per lane (IMG_WIDTH < NUM_WIDTH)
SHIFT_WIDTH, 8, width of the shift sideband
CNT_WIDTH, 16, width of the saturation counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
up_data  input  LANES*NUM_WIDTH  lane i at [i*NUM_WIDTH +: NUM_WIDTH], signed
up_shift  input  SHIFT_WIDTH  right-shift amount for this beat
up_round  input  1  0 = truncate (floor), 1 = round half up
up_relu  input  1  1 = clamp negative results to 0
up_valid  input  1  beat valid
up_ready  output  1  beat accepted when up_valid & up_ready
dn_data  output  LANES*IMG_WIDTH  lane i at [i*IMG_WIDTH +: IMG_WIDTH], signed
dn_sat  output  LANES  per-lane saturation flag for the dn_data beat
dn_valid  output  1  output beat valid
dn_ready  input  1  downstream accepts when dn_valid & dn_ready
sat_clear  input  1  synchronous clear of sat_count
sat_count  output  CNT_WIDTH  number of beats leaving with any dn_sat bit set

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids 0, dn_valid 0, dn_data 0, dn_sat 0, sat_count 0. up_ready is 0 while rst_n is low. Any in-flight beats are dropped.
- Pipeline has three registered stages (S1 shift/round, S2 saturate/ReLU, S3 output); each stage carries its own valid bit.
- Advance enable: en = ~dn_valid | dn_ready. When en=1, all stages shift one step; when en=0, all stages hold. up_ready = en.
- Latency is exactly 3 clk from acceptance to dn_valid when dn_ready stays high. Throughput is 1 beat/clk. Beat order is preserved. No beat is lost or duplicated under any dn_ready pattern.
- Shift and mode sidebands are sampled together with the beat, so config can change every beat.
- Effective shift s = min(up_shift, NUM_WIDTH-1).
- S1 per lane, in NUM_WIDTH+1 signed bits x = sign-extended up_data lane:
  - truncate: r = x >>> s (arithmetic, floor toward -inf).
  - round: r = (x + (s>0 ? 2^(s-1) : 0)) >>> s. The extra bit prevents wrap on the addition.
- S2 per lane:
  - if r > 2^(IMG_WIDTH-1)-1: out = IMG_MAX, sat = 1.
  - if r < -2^(IMG_WIDTH-1): out = IMG_MIN, sat = 1.
  - else out = r[IMG_WIDTH-1:0], sat = 0.
  - Then if relu and out negative: out = 0. ReLU does not set sat, but a lane saturated to IMG_MIN under relu outputs 0 with sat = 1.
- S3 registers dn_data and dn_sat; these are held stable while dn_valid & ~dn_ready.
- sat_count increments by 1 on each dn_valid & dn_ready beat with |dn_sat, and saturates at all-ones.
  - sat_clear has priority: it zeroes the counter in the same cycle and a coincident increment is discarded.
- When stage valid = 0, the data registers are don't-care but must not toggle dn_data. dn_data only updates on a valid beat entering S3.

Decomposition:
- Package rescale_pkg: round-mode constants (RND_TRUNC=0, RND_HALF_UP=1), and functions img_max(IMG_WIDTH) / img_min(IMG_WIDTH).
- Sub-module rescale_lane: one lane's S1/S2 datapath (shift, round, saturate, ReLU) with an enable input. It is instantiated LANES times by a generate loop.
- The top level holds the valid pipeline, the handshake, S3 and the counter.

Test Plan:
- Lane values 0x12345, 24, -24, 7 with shift 4, round 0, dn_ready 1 -> after 3 clk dn lanes 0x1234, 1, -2, 0; with round 1 -> 0x1234, 2, -1, 0; dn_sat 0.
- Lanes 2^20 and -2^20 with shift 4 -> 0x7FFF and 0x8000, dn_sat bits set, sat_count 1. Lane 65535 with shift 1 and round 1 -> 0x7FFF with sat set, covering the rounding-carry overflow.
- Lane -5 with shift 0, relu 1 -> 0x0000, sat 0. Lane -2^20 with shift 4, relu 1 -> 0x0000, sat 1.
- dn_ready low for 6 clk while 5 beats are offered -> up_ready drops after 3 acceptances, dn_data is stable during the stall, and all 5 beats emerge in order after release with no loss.
- up_shift 200 on lane 1 -> treated as shift 32, result 0 (or -1 for a negative input). sat_clear coincident with a saturating output beat -> sat_count 0.
- rst_n pulsed low mid-stream with 3 beats in flight -> dn_valid 0 immediately (asynchronous), no stale beat emerges after release, and the first new beat appears with 3 clk latency.
